fifo_uart_tx: RTL
=================

# fifo_uart_tx

Byte-stream consumer for the 16-deep 8-bit `fifo` block. It pops bytes through the FIFO's `rd_en`/`dout`/`empty` read port and serialises each byte as an asynchronous UART frame on `tx`. It is the read-side partner of the FIFO: upstream logic writes the FIFO, and this block drains it onto the serial line.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal values are 4 and above.
- `PARITY_MODE`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: number of stop bits; 1 or 2.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  allows new frames to start; does not abort a frame in progress.
- `fifo_empty`  in  1  connects to FIFO `empty`.
- `fifo_dout`  in  8  connects to FIFO `dout`.
- `fifo_rd_en`  out  1  connects to FIFO `rd_en`; registered, single-cycle pulse.
- `tx`  out  1  serial line; registered; idles high.
- `busy`  out  1  high from the REQ state through the end of STOP.
- `frames_sent`  out  16  count of completed frames; wraps modulo 2^16.

## Operation
- FSM states: IDLE, REQ, LOAD, START, DATA, PARITY, STOP.
- IDLE → REQ when `enable && !fifo_empty`. `fifo_rd_en` is 1 only while in REQ.
- REQ → LOAD after exactly 1 cycle. The FIFO updates `dout` on the edge that samples `rd_en`.
- LOAD lasts 1 cycle. On its closing edge:
  - `fifo_dout` is latched into the shift register;
  - parity is computed;
  - `tx` is set to 0;
  - the FSM enters START.
- START holds `tx`=0 for CLKS_PER_BIT cycles, then DATA.
- DATA sends 8 bits, LSB first, each for CLKS_PER_BIT cycles.
- After DATA: go to PARITY if PARITY_MODE≠0, otherwise STOP.
- PARITY bit value:
  - even mode: XOR of the data bits;
  - odd mode: inverse of that XOR.
- STOP holds `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles.
- On the last STOP cycle:
  - `frames_sent` increments (0xFFFF → 0x0000);
  - next state is REQ if `enable && !fifo_empty`, otherwise IDLE.
- Exactly one FIFO pop per frame. No read is issued while a frame is in progress.
- `enable` falling mid-frame: the current frame completes; no new REQ follows.
- `fifo_empty` is sampled only in IDLE and on the last STOP cycle. By then the FIFO's lagging flag has settled, because CLKS_PER_BIT ≥ 4.
- Bit timer: counts 0..CLKS_PER_BIT-1 and pulses `bit_done` on the terminal count. It is cleared when entering START.
- Bit index is 3 bits, 0..7. DATA exits when index 7 receives `bit_done`.

## Timing
- Reset values, effective the cycle after the `reset` edge:
  - `tx`=1, `fifo_rd_en`=0, `busy`=0, `frames_sent`=0;
  - FSM in IDLE; timer, bit index and shift register all 0.
- Reset mid-frame: the frame is abandoned, the popped byte is lost, and `tx` is 1 on the next cycle.
- Latency, with E0 = the edge at which IDLE sees the start condition:
  - `fifo_rd_en` is high during E0..E1;
  - LOAD is E1..E2;
  - `tx` falls at E2;
  - data bit i starts at E2 + CLKS_PER_BIT×(1+i).
- Frame length from E2: CLKS_PER_BIT×(9 + parity + STOP_BITS) cycles.
- Back-to-back frames: the line stays high for 2 extra cycles (REQ + LOAD) between the stop bit and the next start bit.
- `busy` rises at E0 and falls on the edge that leaves STOP for IDLE.

## Structure
- Shared package `uart_pkg` contains:
  - the FSM state enum;
  - PARITY_NONE/EVEN/ODD constants;
  - a frame-length helper function.
- Sub-module `uart_bit_timer` (parameter CLKS_PER_BIT; ports `clk`, `reset`, `clear`, `bit_done`). Its counter width is $clog2(CLKS_PER_BIT).
- The top level holds the FSM, shift register, parity, bit index and `frames_sent`.

## Test plan
- Reset: assert `reset` mid-DATA with bit 3 on the line → next cycle `tx`=1, `busy`=0, `fifo_rd_en`=0, `frames_sent`=0; no further pops.
- Single byte 0xA5, CLKS_PER_BIT=16, no parity, 1 stop → one `rd_en` pulse; `tx` low 16 cycles from E2; data 1,0,1,0,0,1,0,1; stop high 16 cycles; `frames_sent`=1; `busy` low afterwards.
- Parity: 0x07 in even mode → parity bit 1; in odd mode → 0. Frame is 11×16 cycles. With STOP_BITS=2, stop is high for 32 cycles.
- Back-to-back: FIFO preloaded with 0x11, 0x22, 0x33 → exactly 3 `rd_en` pulses; 2 extra high cycles between frames; then IDLE with `fifo_empty`=1.
- `enable` dropped during frame 1 of 2 queued bytes → frame 1 completes; no second `rd_en`; `frames_sent`=1. Re-asserting `enable` sends 0x22.
- Counter wrap: CLKS_PER_BIT=4, continuous stream, `frames_sent` preset via hierarchy to 0xFFFE → reads 0xFFFF and then 0x0000 after two frames.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Serial-line cycles for one frame, counted from the falling edge of the start bit.
    function automatic int frame_cycles(input int clks_per_bit, input int parity_mode,
                                        input int stop_bits);
        return clks_per_bit * (9 + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign bit_done = (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from a 16x8 FIFO read port and serialises each one as a UART frame on tx.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_dout,
    output logic        fifo_rd_en,
    output logic        tx,
    output logic        busy,
    output logic [15:0] frames_sent
);

    localparam logic STOP_LAST = (STOP_BITS == 2);

    tx_state_t  state, state_next;
    logic [7:0] shift_reg;
    logic       parity_bit;
    logic [2:0] bit_idx;
    logic       stop_idx;
    logic       bit_done;
    logic       start_ok;
    logic       tx_next;
    logic       rd_en_next;
    logic       frame_done;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == LOAD),
        .bit_done (bit_done)
    );

    assign start_ok = enable && !fifo_empty;
    assign busy     = (state != IDLE);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        tx_next    = tx;
        frame_done = 1'b0;
        case (state)
            IDLE:   if (start_ok) state_next = REQ;
            REQ:    state_next = LOAD;
            LOAD: begin
                state_next = START;
                tx_next    = 1'b0;
            end
            START: if (bit_done) begin
                state_next = DATA;
                tx_next    = shift_reg[0];
            end
            DATA: if (bit_done) begin
                if (bit_idx == 3'd7) begin
                    if (PARITY_MODE != PARITY_NONE) begin
                        state_next = PARITY;
                        tx_next    = parity_bit;
                    end else begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end
                end else begin
                    // shift_reg[0] is the bit on the line now; [1] is the one after it.
                    tx_next = shift_reg[1];
                end
            end
            PARITY: if (bit_done) begin
                state_next = STOP;
                tx_next    = 1'b1;
            end
            STOP: if (bit_done && stop_idx == STOP_LAST) begin
                frame_done = 1'b1;
                state_next = start_ok ? REQ : IDLE;
            end
            default: state_next = IDLE;
        endcase
        rd_en_next = (state_next == REQ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tx          <= 1'b1;
            fifo_rd_en  <= 1'b0;
            frames_sent <= '0;
            shift_reg   <= '0;
            parity_bit  <= 1'b0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
        end else begin
            state      <= state_next;
            tx         <= tx_next;
            fifo_rd_en <= rd_en_next;
            if (frame_done)
                frames_sent <= frames_sent + 16'd1;
            case (state)
                LOAD: begin
                    shift_reg  <= fifo_dout;
                    parity_bit <= (^fifo_dout) ^ (PARITY_MODE == PARITY_ODD);
                    bit_idx    <= '0;
                    stop_idx   <= 1'b0;
                end
                DATA: if (bit_done) begin
                    shift_reg <= {1'b0, shift_reg[7:1]};
                    bit_idx   <= bit_idx + 3'd1;
                end
                STOP: if (bit_done) stop_idx <= ~stop_idx;
                default: ;
            endcase
        end
    end

endmodule
